// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: drives a JK flip-flop bank to a target word using
// excitation-table J/K for one cycle, then checks and counts mismatches.
module jk_excitation_driver #(
    parameter int WIDTH     = 8,
    parameter bit DC_POLICY = 1'b0
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             tgt_valid_i,
    output logic             tgt_ready_o,
    input  logic [WIDTH-1:0] tgt_data_i,
    input  logic [WIDTH-1:0] q_fb_i,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             mismatch_o,
    output logic [WIDTH-1:0] mismatch_bits_o,
    output logic [7:0]       err_count_o,
    input  logic             err_clr_i
);
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d, j_q, j_d, k_q, k_d, mm_bits_q, mm_bits_d;
    logic [WIDTH-1:0] diff, exc_j, exc_k;
    logic done_q, done_d, mm_q, mm_d, accept;
    logic [7:0] err_q, err_d, err_base;

    assign tgt_ready_o = (state_q == IDLE) && !Reset;
    assign busy_o      = state_q != IDLE;
    assign accept      = tgt_valid_i && tgt_ready_o;
    assign diff        = q_fb_i ^ tgt_q;
    // Don't-care J (Q=1) and don't-care K (Q=0) both resolve to DC_POLICY.
    assign exc_j    = DC_POLICY ? (q_fb_i | tgt_data_i) : (~q_fb_i & tgt_data_i);
    assign exc_k    = DC_POLICY ? ~(q_fb_i & tgt_data_i) : (q_fb_i & ~tgt_data_i);
    assign err_base = err_clr_i ? 8'd0 : err_q;

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        j_d       = '0;
        k_d       = '0;
        done_d    = 1'b0;
        mm_d      = mm_q;
        mm_bits_d = mm_bits_q;
        err_d     = err_base;
        case (state_q)
            IDLE: begin
                state_d = accept ? DRIVE : IDLE;
                tgt_d   = accept ? tgt_data_i : tgt_q;
                j_d     = accept ? exc_j : '0;
                k_d     = accept ? exc_k : '0;
            end
            DRIVE: state_d = CHECK;
            CHECK: begin
                state_d   = IDLE;
                done_d    = 1'b1;
                mm_d      = |diff;
                mm_bits_d = diff;
                err_d     = (|diff && err_base != 8'hFF) ? err_base + 8'd1 : err_base;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            tgt_q     <= '0;
            j_q       <= '0;
            k_q       <= '0;
            done_q    <= 1'b0;
            mm_q      <= 1'b0;
            mm_bits_q <= '0;
            err_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            j_q       <= j_d;
            k_q       <= k_d;
            done_q    <= done_d;
            mm_q      <= mm_d;
            mm_bits_q <= mm_bits_d;
            err_q     <= err_d;
        end
    end

    assign j_o             = j_q;
    assign k_o             = k_q;
    assign done_o          = done_q;
    assign mismatch_o      = mm_q;
    assign mismatch_bits_o = mm_bits_q;
    assign err_count_o     = err_q;
endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb_jk_excitation_driver: two DUTs (DC_POLICY 0 and 1) each driving a JK bank
// model, checked every cycle against a transfer-age reference model.
module tb_jk_excitation_driver;
    logic CLK = 1'b0;
    logic Reset = 1'b1;
    logic tgt_valid = 1'b0;
    logic err_clr = 1'b0;
    logic [7:0] tgt_data = 8'h00;
    logic [7:0] stuck = 8'h00;
    logic       rdy[2], busy[2], done[2], mm[2];
    logic [7:0] j_w[2], k_w[2], mmb[2], err_w[2], qfb[2];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0] bank;
        jk_excitation_driver #(.WIDTH(8), .DC_POLICY(g == 1)) u_dut (
            .CLK(CLK), .Reset(Reset), .tgt_valid_i(tgt_valid), .tgt_ready_o(rdy[g]),
            .tgt_data_i(tgt_data), .q_fb_i(qfb[g]), .j_o(j_w[g]), .k_o(k_w[g]),
            .busy_o(busy[g]), .done_o(done[g]), .mismatch_o(mm[g]),
            .mismatch_bits_o(mmb[g]), .err_count_o(err_w[g]), .err_clr_i(err_clr)
        );
        always_ff @(posedge CLK or posedge Reset)
            if (Reset) bank <= 8'h00;
            else bank <= ((j_w[g] & ~bank) | (~k_w[g] & bank)) & ~stuck;
        assign qfb[g] = bank;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
        end
    endtask

    // Excitation table indexed by {Q, target}, one row per don't-care policy.
    bit jt[2][4] = '{'{0, 1, 0, 0}, '{0, 1, 1, 1}};
    bit kt[2][4] = '{'{0, 0, 1, 0}, '{1, 1, 1, 0}};
    // age: cycles since the accepting handshake edge (1=drive, 2=check, 3=done).
    int         age[2] = '{100, 100};
    int         m_err[2] = '{0, 0};
    logic [7:0] m_tgt[2], m_j[2], m_k[2], m_mmb[2], m_bank[2];
    bit         m_mm[2];

    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            logic [7:0] d;
            bit exp_rdy;
            int base;
            if (Reset) begin
                age[i] = 100; m_tgt[i] = 0; m_mmb[i] = 0; m_mm[i] = 0;
                m_err[i] = 0; m_bank[i] = 0; m_j[i] = 0; m_k[i] = 0;
            end
            exp_rdy = !Reset && age[i] != 1 && age[i] != 2;
            chk($sformatf("ready%0d", i), rdy[i], exp_rdy);
            chk($sformatf("busy%0d", i), busy[i], age[i] == 1 || age[i] == 2);
            chk($sformatf("j%0d", i), j_w[i], age[i] == 1 ? m_j[i] : 8'h00);
            chk($sformatf("k%0d", i), k_w[i], age[i] == 1 ? m_k[i] : 8'h00);
            chk($sformatf("done%0d", i), done[i], age[i] == 3);
            chk($sformatf("mismatch%0d", i), mm[i], m_mm[i]);
            chk($sformatf("mm_bits%0d", i), mmb[i], m_mmb[i]);
            chk($sformatf("err_count%0d", i), err_w[i], m_err[i]);
            chk($sformatf("q_fb%0d", i), qfb[i], m_bank[i]);
            if (!Reset) begin
                base = err_clr ? 0 : m_err[i];
                if (age[i] == 2) begin
                    d = m_bank[i] ^ m_tgt[i];
                    m_mmb[i] = d;
                    m_mm[i] = d != 0;
                    m_err[i] = d != 0 ? (base >= 255 ? 255 : base + 1) : base;
                end else m_err[i] = base;
                if (tgt_valid && exp_rdy) begin
                    m_tgt[i] = tgt_data;
                    for (int b = 0; b < 8; b++) begin
                        m_j[i][b] = jt[i][{m_bank[i][b], tgt_data[b]}];
                        m_k[i][b] = kt[i][{m_bank[i][b], tgt_data[b]}];
                    end
                end
                m_bank[i] = (age[i] == 1 ? m_tgt[i] : m_bank[i]) & ~stuck;
                age[i] = (tgt_valid && exp_rdy) ? 1 : (age[i] < 100 ? age[i] + 1 : 100);
            end
        end
    end

    task automatic send(input logic [7:0] t);
        bit ok = 0;
        @(posedge CLK); #1;
        tgt_valid = 1; tgt_data = t;
        for (int w = 0; w < 20 && !ok; w++) begin
            @(negedge CLK);
            ok = rdy[0];
        end
        @(posedge CLK); #1;
        tgt_valid = 0;
        chk("send_handshake", ok, 1);
    endtask

    initial begin
        int n, last;
        repeat (3) @(posedge CLK);
        #1 Reset = 0;
        @(negedge CLK);
        chk("rdy_after_reset", rdy[0], 1);
        send(8'hA5);
        @(negedge CLK);
        chk("lit_j_a5", j_w[0], 8'hA5); chk("lit_k_a5", k_w[0], 8'h00);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("lit_done_a5", done[0], 1); chk("lit_mm_a5", mm[0], 0); chk("lit_err_a5", err_w[0], 0);
        send(8'h0F);
        @(negedge CLK);
        chk("lit_j_0f", j_w[0], 8'h0A); chk("lit_k_0f", k_w[0], 8'hA0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("lit_done_0f", done[0], 1); chk("lit_mm_0f", mm[0], 0);
        send(8'h3C);
        repeat (2) @(posedge CLK);
        send(8'hC3);
        @(negedge CLK);
        chk("lit_j1_c3", j_w[1], 8'hFF); chk("lit_k1_c3", k_w[1], 8'hFF);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("lit_q1_c3", qfb[1], 8'hC3); chk("lit_mm1_c3", mm[1], 0);
        @(posedge CLK); #1 stuck = 8'h04;
        send(8'h04);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("lit_fault_mm", mm[0], 1); chk("lit_fault_bits", mmb[0], 8'h04);
        chk("lit_fault_err", err_w[0], 1);
        @(posedge CLK); #1 tgt_valid = 1;
        repeat (785) @(posedge CLK);
        #1 tgt_valid = 0;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        chk("lit_saturate", err_w[0], 255);
        send(8'h04);
        @(posedge CLK); #1 err_clr = 1;
        @(posedge CLK); #1 err_clr = 0;
        @(negedge CLK);
        chk("lit_clr_coincident", err_w[0], 1);
        @(posedge CLK); #1 err_clr = 1;
        @(posedge CLK); #1 err_clr = 0;
        @(negedge CLK);
        chk("lit_clr_idle", err_w[0], 0);
        @(posedge CLK); #1 stuck = 8'h00;
        tgt_valid = 1; tgt_data = 8'h11; n = 0; last = 0;
        for (int w = 0; w < 40 && n < 4; w++) begin
            @(negedge CLK);
            if (rdy[0]) begin
                if (n > 0) chk("b2b_gap", cyc - last, 3);
                last = cyc; n++;
            end
            @(posedge CLK); #1;
            if (rdy[0] == 0 && n > 0) tgt_data = 8'h11 * 8'(n + 1);
        end
        tgt_valid = 0;
        chk("b2b_count", n, 4);
        repeat (4) @(posedge CLK);
        send(8'h5A);
        #1 Reset = 1;
        #1 chk("lit_rst_j", j_w[0] | j_w[1], 0); chk("lit_rst_k", k_w[0] | k_w[1], 0);
        @(posedge CLK); #1 Reset = 0;
        @(negedge CLK);
        chk("lit_rst_rdy", rdy[0], 1); chk("lit_rst_err", err_w[0], 0);
        repeat (3) @(posedge CLK);
        send(8'h66);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("lit_post_rst_done", done[0], 1); chk("lit_post_rst_mm", mm[0], 0);
        for (int r = 0; r < 1500; r++) begin
            @(posedge CLK); #1;
            tgt_valid = 1'($urandom_range(0, 1));
            tgt_data = 8'($urandom);
            err_clr = $urandom_range(0, 15) == 0;
            if ($urandom_range(0, 31) == 0) stuck = $urandom_range(0, 1) ? 8'($urandom) : 8'h00;
            Reset = $urandom_range(0, 149) == 0;
        end
        @(posedge CLK); #1;
        Reset = 0; tgt_valid = 0; err_clr = 0;
        repeat (5) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/jk_excitation_driver.md
# jk_excitation_driver

Drives a WIDTH-bit bank of JK flip-flops (sharing CLK and Reset) to a requested target word. For each accepted target, it derives per-bit J/K excitation from the bank's current Q using the JK excitation table. It applies J/K for exactly one clock, then checks that the bank's Q reached the target. Mismatches are counted, so the block acts as both the stimulus source and the self-checker for JK register banks in the design.

## Interface
- WIDTH, 8: number of JK bits driven and checked.
- DC_POLICY, 0: resolution of excitation don't-cares. 0 means don't-care resolves to 0; 1 means don't-care resolves to 1.
- CLK  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- tgt_valid  input  1  target word offered.
- tgt_ready  output  1  block can accept a target (high only in IDLE).
- tgt_data  input  WIDTH  requested next Q of the bank.
- q_fb  input  WIDTH  Q outputs of the driven JK bank.
- J  output  WIDTH  registered J inputs to the bank.
- K  output  WIDTH  registered K inputs to the bank.
- busy  output  1  high in DRIVE and CHECK.
- done  output  1  one-cycle pulse when a transfer completes.
- mismatch  output  1  result of the last completed transfer; 1 means Q differed from the target.
- mismatch_bits  output  WIDTH  q_fb XOR target captured at the last check.
- err_count  output  8  number of failed transfers; saturates at 255.
- err_clr  input  1  synchronous clear of err_count.

## Operation
- The FSM has three states: IDLE, DRIVE and CHECK.
- **IDLE**
  - tgt_ready=1 and J=K=0, so the bank holds.
  - On tgt_valid&&tgt_ready, the block captures tgt_data into tgt_q and registers J/K, computed per bit from q_fb and tgt_data, then moves to DRIVE.
- **Excitation per bit (Q→target), DC_POLICY=0:**
  - 0→0: J=0, K=0
  - 0→1: J=1, K=0
  - 1→0: J=0, K=1
  - 1→1: J=0, K=0
- **Excitation per bit (Q→target), DC_POLICY=1:**
  - 0→0: J=0, K=1
  - 0→1: J=1, K=1
  - 1→0: J=1, K=1
  - 1→1: J=1, K=0
- **DRIVE**
  - Lasts exactly one cycle with J/K held.
  - On the next edge, the bank samples J/K, J/K return to 0, and the FSM moves to CHECK.
- **CHECK**
  - Lasts one cycle.
  - On the exiting edge: mismatch_bits<=q_fb^tgt_q, mismatch<=|(q_fb^tgt_q), done<=1.
  - err_count increments (saturating at 255) when a mismatch occurs.
  - The FSM then moves to IDLE.
- **err_clr**
  - Sets err_count to 0.
  - If err_clr coincides with a failing CHECK exit, err_count becomes 1: clear first, then increment.
- **tgt_valid outside IDLE:** ignored. tgt_ready is low, and no data is captured.
- **Reset, at any time including mid-DRIVE or mid-CHECK**
  - State=IDLE.
  - J=K=0, tgt_q=0, done=0, mismatch=0, mismatch_bits=0, err_count=0, busy=0.
  - tgt_ready=0 while Reset is asserted, and 1 from the first cycle after release.
  - An in-flight target is discarded with no done pulse.
- busy and tgt_ready are decoded from state.

## Timing
- Cycle N: handshake.
- Cycle N+1: DRIVE, with J/K valid.
- Edge at the end of N+1: the bank updates Q.
- Cycle N+2: CHECK, with q_fb compared against tgt_q.
- Cycle N+3: IDLE. done=1, mismatch and mismatch_bits are valid, and tgt_ready=1.
- Minimum period per target is 3 cycles. A target can be accepted in the same cycle that done is high.
- q_fb must be stable during the handshake cycle. This holds because J=K=0 in IDLE.
- mismatch, mismatch_bits and err_count hold their values until the next CHECK exit, err_clr, or Reset.
- J/K are never nonzero outside DRIVE.

## Test plan
- **Basic set/clear, DC_POLICY=0, bank model at Q=0x00:**
  - Target 0xA5 gives J=0xA5, K=0x00 in DRIVE.
  - Next target 0x0F gives J=0x0A, K=0xA0.
  - Both transfers give done=1, mismatch=0, err_count=0.
- **DC_POLICY=1, Q=0x3C, target 0xC3:** J=0xFF, K=0xFF (all toggle). Then Q=0xC3 and mismatch=0.
- **Fault injection:** the bank model holds bit 2 stuck-at-0; target 0x04 gives mismatch=1, mismatch_bits=0x04, err_count=1.
- **Saturation and clear:**
  - 260 failing transfers give err_count=255.
  - err_clr coincident with a failing CHECK exit gives err_count=1.
  - An idle err_clr gives 0.
- **Back-to-back:** tgt_valid held high with 4 targets gives a handshake every 3rd cycle. tgt_valid during DRIVE/CHECK is not accepted, and every done is correct.
- **Reset mid-DRIVE:** J=K=0 immediately. No done pulse and err_count=0. After release, tgt_ready=1 and the next target completes normally.
